cnn_frame_scheduler: RTL and testbench

Sequences the CNN inference datapath against the camera/screen raster. Watches the incoming `screen_x_pos`/`screen_y_pos` scan and captures the pixels inside a fixed region of interest into the input buffer, in row-major order. Once the window is full, it launches one inference and waits for `product_rdy`. It then latches the `n0`/`n1` classifier outputs and reports them. The block sits between the raster source and `top`'s input buffer/start logic; frames that arrive while an inference is running are counted and dropped.

---
 rtl/cnn_frame_scheduler_if.sv | 40 ++++
 rtl/cnn_frame_scheduler.sv | 149 ++++++++++++++
 tb/tb_cnn_frame_scheduler.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_frame_scheduler_if.sv
// Raster-in / buffer-out / datapath handshake bundle for cnn_frame_scheduler.
interface cnn_frame_scheduler_if #(
  parameter int X_BITS  = 10,
  parameter int Y_BITS  = 10,
  parameter int PIXEL_W = 9,
  parameter int OUT_W   = 16,
  parameter int ADDR_W  = 10
);
  logic [X_BITS-1:0]  screen_x_pos;
  logic [Y_BITS-1:0]  screen_y_pos;
  logic [PIXEL_W-1:0] pixel_in;
  logic               pixel_valid;
  logic               buf_wr_en;
  logic [ADDR_W-1:0]  buf_wr_addr;
  logic [PIXEL_W-1:0] buf_wr_data;
  logic               start;
  logic               product_rdy;
  logic [OUT_W-1:0]   n0_in;
  logic [OUT_W-1:0]   n1_in;
  logic [OUT_W-1:0]   n0;
  logic [OUT_W-1:0]   n1;
  logic               result_valid;
  logic               busy;
  logic               timeout_err;
  logic [7:0]         drop_count;

  modport master (
    output screen_x_pos, screen_y_pos, pixel_in, pixel_valid,
    output product_rdy, n0_in, n1_in,
    input  buf_wr_en, buf_wr_addr, buf_wr_data, start,
    input  n0, n1, result_valid, busy, timeout_err, drop_count
  );

  modport slave (
    input  screen_x_pos, screen_y_pos, pixel_in, pixel_valid,
    input  product_rdy, n0_in, n1_in,
    output buf_wr_en, buf_wr_addr, buf_wr_data, start,
    output n0, n1, result_valid, busy, timeout_err, drop_count
  );
endinterface

// File: rtl/cnn_frame_scheduler.sv
// Captures a raster window into the input buffer, launches one inference,
// then latches the classifier outputs; frames arriving mid-inference are dropped.
module cnn_frame_scheduler #(
  parameter int X_BITS  = 10,
  parameter int Y_BITS  = 10,
  parameter int PIXEL_W = 9,
  parameter int OUT_W   = 16,
  parameter int WIN_X0  = 0,
  parameter int WIN_Y0  = 0,
  parameter int WIN_W   = 28,
  parameter int WIN_H   = 28,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 4095
) (
  input logic                  clock,
  input logic                  reset,
  cnn_frame_scheduler_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] COMPUTE = 2'd2;

  localparam int               CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIN_W * WIN_H - 1);
  localparam logic [X_BITS:0]  X_LO = (X_BITS + 1)'(WIN_X0);
  localparam logic [X_BITS:0]  X_HI = (X_BITS + 1)'(WIN_X0 + WIN_W - 1);
  localparam logic [Y_BITS:0]  Y_LO = (Y_BITS + 1)'(WIN_Y0);
  localparam logic [Y_BITS:0]  Y_HI = (Y_BITS + 1)'(WIN_Y0 + WIN_H - 1);

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d, base_addr;
  logic               full_q, full_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [PIXEL_W-1:0] wr_data_q, wr_data_d;
  logic               start_q, start_d;
  logic               rv_q, rv_d;
  logic [OUT_W-1:0]   n0_q, n0_d, n1_q, n1_d;
  logic               terr_q, terr_d;
  logic [7:0]         drop_q, drop_d;
  logic               busy_q;
  logic               fs, in_win, drop_inc;

  assign fs = bus.pixel_valid && (bus.screen_x_pos == '0) && (bus.screen_y_pos == '0);
  assign in_win = bus.pixel_valid
                  && ({1'b0, bus.screen_x_pos} >= X_LO) && ({1'b0, bus.screen_x_pos} <= X_HI)
                  && ({1'b0, bus.screen_y_pos} >= Y_LO) && ({1'b0, bus.screen_y_pos} <= Y_HI);
  assign drop_inc = fs && (drop_q != 8'hFF);

  // full_q marks the cycle the final write is on the bus; COMPUTE (and start) follow it.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    full_d    = full_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    start_d   = 1'b0;
    rv_d      = 1'b0;
    n0_d      = n0_q;
    n1_d      = n1_q;
    terr_d    = terr_q;
    drop_d    = drop_q;
    base_addr = fs ? '0 : addr_q;
    case (state_q)
      IDLE, CAPTURE: begin
        if (state_q == CAPTURE && full_q) begin
          state_d = COMPUTE;
          full_d  = 1'b0;
          start_d = 1'b1;
          cnt_d   = '0;
          if (drop_inc) drop_d = drop_q + 8'd1;
        end else if (fs || state_q == CAPTURE) begin
          state_d = CAPTURE;
          addr_d  = base_addr;
          if (in_win) begin
            wr_en_d   = 1'b1;
            wr_addr_d = base_addr;
            wr_data_d = bus.pixel_in;
            addr_d    = base_addr + 1'b1;
            if (base_addr == LAST_ADDR) full_d = 1'b1;
          end
        end
      end
      COMPUTE: begin
        cnt_d = cnt_q + 1'b1;
        if (drop_inc) drop_d = drop_q + 8'd1;
        if (bus.product_rdy) begin
          n0_d    = bus.n0_in;
          n1_d    = bus.n1_in;
          rv_d    = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == TMO_LAST) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      full_q    <= 1'b0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      start_q   <= 1'b0;
      rv_q      <= 1'b0;
      n0_q      <= '0;
      n1_q      <= '0;
      terr_q    <= 1'b0;
      drop_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      full_q    <= full_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      start_q   <= start_d;
      rv_q      <= rv_d;
      n0_q      <= n0_d;
      n1_q      <= n1_d;
      terr_q    <= terr_d;
      drop_q    <= drop_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign bus.buf_wr_en    = wr_en_q;
  assign bus.buf_wr_addr  = wr_addr_q;
  assign bus.buf_wr_data  = wr_data_q;
  assign bus.start        = start_q;
  assign bus.n0           = n0_q;
  assign bus.n1           = n1_q;
  assign bus.result_valid = rv_q;
  assign bus.busy         = busy_q;
  assign bus.timeout_err  = terr_q;
  assign bus.drop_count   = drop_q;
endmodule

// File: tb/tb_cnn_frame_scheduler.sv
// Self-checking bench: a frame-level reference model is compared against the DUT
// every cycle, plus literal expectations for counts, results and reset values.
module tb_cnn_frame_scheduler;
  localparam int COLS = 40;
  localparam int ROWS = 32;
  localparam int WW   = 28;
  localparam int WH   = 28;
  localparam int NPIX = WW * WH;
  localparam int TMO  = 4095;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int writesSeen = 0;
  int startsSeen = 0;
  int rvSeen = 0;
  logic        stimRdy = 1'b0;
  logic [15:0] stimN0 = '0;
  logic [15:0] stimN1 = '0;

  cnn_frame_scheduler_if #(.X_BITS(10), .Y_BITS(10), .PIXEL_W(9), .OUT_W(16), .ADDR_W(10)) bus();

  cnn_frame_scheduler #(
    .X_BITS(10), .Y_BITS(10), .PIXEL_W(9), .OUT_W(16),
    .WIN_X0(0), .WIN_Y0(0), .WIN_W(WW), .WIN_H(WH), .ADDR_W(10), .TIMEOUT(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  // Reference model: frame progress tracked as pixel count and phase flags.
  bit mCapturing, mLaunch, mComputing, mFs, mInWin;
  int mCount, mCycles, mX, mY;
  bit eWrEn, eStart, eRv, eBusy, eTerr;
  int eWrAddr, eWrData, eN0, eN1, eDrop;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mCapturing = 0; mLaunch = 0; mComputing = 0; mCount = 0; mCycles = 0;
      eWrEn = 0; eWrAddr = 0; eWrData = 0; eStart = 0; eN0 = 0; eN1 = 0;
      eRv = 0; eBusy = 0; eTerr = 0; eDrop = 0;
    end else begin
      mX = int'(bus.screen_x_pos);
      mY = int'(bus.screen_y_pos);
      mFs = bus.pixel_valid && mX == 0 && mY == 0;
      mInWin = bus.pixel_valid && mX < WW && mY < WH;
      eWrEn = 0; eStart = 0; eRv = 0;
      if (mComputing) begin
        if (mFs && eDrop < 255) eDrop++;
        if (bus.product_rdy) begin
          eN0 = int'(bus.n0_in);
          eN1 = int'(bus.n1_in);
          eRv = 1;
          mComputing = 0;
        end else begin
          mCycles++;
          if (mCycles == TMO) begin
            eTerr = 1;
            mComputing = 0;
          end
        end
      end else if (mLaunch) begin
        if (mFs && eDrop < 255) eDrop++;
        mLaunch = 0; mComputing = 1; mCycles = 0; eStart = 1;
      end else if (mFs || mCapturing) begin
        if (mFs) begin
          mCapturing = 1;
          mCount = 0;
        end
        if (mInWin) begin
          eWrEn = 1; eWrAddr = mCount; eWrData = int'(bus.pixel_in);
          mCount++;
          if (mCount == NPIX) begin
            mCapturing = 0;
            mLaunch = 1;
          end
        end
      end
      eBusy = mCapturing || mLaunch || mComputing;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      checkOutput("buf_wr_en", 32'(bus.buf_wr_en), 32'(eWrEn));
      checkOutput("buf_wr_addr", 32'(bus.buf_wr_addr), eWrAddr);
      checkOutput("buf_wr_data", 32'(bus.buf_wr_data), eWrData);
      checkOutput("start", 32'(bus.start), 32'(eStart));
      checkOutput("n0", 32'(bus.n0), eN0);
      checkOutput("n1", 32'(bus.n1), eN1);
      checkOutput("result_valid", 32'(bus.result_valid), 32'(eRv));
      checkOutput("busy", 32'(bus.busy), 32'(eBusy));
      checkOutput("timeout_err", 32'(bus.timeout_err), 32'(eTerr));
      checkOutput("drop_count", 32'(bus.drop_count), eDrop);
      if (bus.buf_wr_en) writesSeen++;
      if (bus.start) startsSeen++;
      if (bus.result_valid) rvSeen++;
    end
  end

  task automatic applyStimulus(input bit valid, input int x, input int y, input int pix);
    @(negedge clock);
    bus.pixel_valid  = valid;
    bus.screen_x_pos = 10'(x);
    bus.screen_y_pos = 10'(y);
    bus.pixel_in     = 9'(pix);
    bus.product_rdy  = stimRdy;
    bus.n0_in        = stimN0;
    bus.n1_in        = stimN1;
  endtask

  // Row-major raster with pixel = x; returns once stopAfter window pixels were driven.
  task automatic scanFrame(input int stopAfter);
    int n = 0;
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < COLS; x++) begin
        applyStimulus(1'b1, x, y, x);
        if (x < WW && y < WH) n++;
        if (n == stopAfter) return;
      end
    end
  endtask

  task automatic waitStart();
    bit seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      applyStimulus(1'b0, 0, 0, 0);
      seen = bus.start;
    end
    checkOutput("start_within_bound", 32'(seen), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 0);
  endtask

  task automatic pulseReady(input logic [15:0] v0, input logic [15:0] v1);
    stimRdy = 1'b1; stimN0 = v0; stimN1 = v1;
    idle(1);
    stimRdy = 1'b0;
    idle(2);
  endtask

  initial begin
    int base;
    int startBase;
    int waited;
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int startBase;
    int waited;
    bus.pixel_valid = 1'b0; bus.screen_x_pos = '0; bus.screen_y_pos = '0;
    bus.pixel_in = '0; bus.product_rdy = 1'b0; bus.n0_in = '0; bus.n1_in = '0;

    @(negedge clock);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_wr_en", 32'(bus.buf_wr_en), 32'd0);
    checkOutput("reset_drop", 32'(bus.drop_count), 32'd0);
    checkOutput("reset_terr", 32'(bus.timeout_err), 32'd0);
    reset = 1'b0;
    idle(2);

    // Full window capture, result 50 cycles after start.
    scanFrame(NPIX);
    waitStart();
    idle(1);
    checkOutput("frame1_writes", writesSeen, NPIX);
    checkOutput("frame1_starts", startsSeen, 1);
    checkOutput("frame1_last_addr", 32'(bus.buf_wr_addr), 783);
    checkOutput("frame1_last_data", 32'(bus.buf_wr_data), 27);
    idle(48);
    pulseReady(16'h0123, 16'h0456);
    checkOutput("result_n0", 32'(bus.n0), 32'h0123);
    checkOutput("result_n1", 32'(bus.n1), 32'h0456);
    checkOutput("result_valid_count", rvSeen, 1);
    checkOutput("idle_after_result", 32'(bus.busy), 32'd0);

    // Withheld product_rdy: timeout after 4095 COMPUTE cycles.
    scanFrame(NPIX);
    waitStart();
    waited = 0;
    while (!bus.timeout_err && waited < TMO + 20) begin
      idle(1);
      waited++;
    end
    checkOutput("timeout_latency", waited, 4095);
    checkOutput("timeout_no_result", rvSeen, 1);
    checkOutput("timeout_busy", 32'(bus.busy), 32'd0);

    // Ready held high through IDLE/CAPTURE; accepted on the start cycle.
    stimRdy = 1'b1; stimN0 = 16'hA5A5; stimN1 = 16'h5A5A;
    scanFrame(NPIX);
    waitStart();
    stimRdy = 1'b0;
    idle(2);
    checkOutput("start_cycle_accept_rv", rvSeen, 2);
    checkOutput("start_cycle_accept_n0", 32'(bus.n0), 32'hA5A5);
    checkOutput("timeout_sticky", 32'(bus.timeout_err), 32'd1);

    // Frames during COMPUTE are dropped, count saturates.
    scanFrame(NPIX);
    waitStart();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 0, 0, 0);
      idle(1);
    end
    checkOutput("drop_three", 32'(bus.drop_count), 32'd3);
    for (int i = 0; i < 297; i++) begin
      applyStimulus(1'b1, 0, 0, 0);
      idle(1);
    end
    checkOutput("drop_saturated", 32'(bus.drop_count), 32'd255);
    checkOutput("drop_still_busy", 32'(bus.busy), 32'd1);
    pulseReady(16'hBEEF, 16'h1234);
    checkOutput("drop_result_n0", 32'(bus.n0), 32'hBEEF);
    checkOutput("drop_result_rv", rvSeen, 3);

    // FS after 100 writes restarts capture.
    base = writesSeen;
    startBase = startsSeen;
    scanFrame(100);
    scanFrame(NPIX);
    waitStart();
    idle(1);
    checkOutput("restart_writes", writesSeen - base, 884);
    checkOutput("restart_starts", startsSeen - startBase, 1);
    checkOutput("restart_last_addr", 32'(bus.buf_wr_addr), 783);
    pulseReady(16'h0001, 16'h0002);

    // Asynchronous reset mid-capture.
    scanFrame(400);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_wr_en", 32'(bus.buf_wr_en), 32'd0);
    checkOutput("async_reset_wr_addr", 32'(bus.buf_wr_addr), 32'd0);
    checkOutput("async_reset_wr_data", 32'(bus.buf_wr_data), 32'd0);
    checkOutput("async_reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("async_reset_terr", 32'(bus.timeout_err), 32'd0);
    checkOutput("async_reset_drop", 32'(bus.drop_count), 32'd0);
    checkOutput("async_reset_n0", 32'(bus.n0), 32'd0);
    checkOutput("async_reset_n1", 32'(bus.n1), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    base = writesSeen;
    scanFrame(1);
    idle(1);
    checkOutput("post_reset_first_addr", 32'(bus.buf_wr_addr), 32'd0);
    scanFrame(NPIX);
    waitStart();
    idle(1);
    checkOutput("post_reset_writes", writesSeen - base, 1 + NPIX);
    pulseReady(16'h7777, 16'h8888);
    checkOutput("post_reset_n1", 32'(bus.n1), 32'h8888);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
